// File: rtl/usb_rx.sv
// USB full-speed receive datapath: line sync, bit recovery, NRZI decode, unstuffing,
// SYNC/PID/EOP framing and payload delivery (CRC bytes held back) to the endpoint FIFO.
module usb_rx #(
  parameter int unsigned CLKS_PER_BIT = 8,
  parameter int unsigned MAX_PAYLOAD  = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       dplus_in,
  input  logic       dminus_in,
  input  logic [6:0] buffer_occupancy,
  output logic [7:0] rx_packet_data,
  output logic       store_rx_packet_data,
  output logic [2:0] rx_packet,
  output logic       rx_data_ready,
  output logic       rx_transfer_active,
  output logic       rx_error
);

  localparam int unsigned CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] SAMPLE_AT = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] WRAP_AT   = CW'(CLKS_PER_BIT - 1);
  localparam logic [7:0]    MAX_BODY  = 8'(MAX_PAYLOAD + 2);
  localparam logic [6:0]    FIFO_FULL = 7'(MAX_PAYLOAD);

  typedef enum logic [2:0] {IDLE, SYNC, PID, BODY, EOP, ERR} state_t;

  state_t state, nxt;

  logic          dp_s1, dp_s2, dp_d, dm_s1, dm_s2;
  logic [CW-1:0] cnt;
  logic          prev_dp;
  logic [7:0]    shift;
  logic [2:0]    bitcnt;
  logic [2:0]    ones;
  logic [7:0]    body_cnt;
  logic [7:0]    hold0, hold1;
  logic [1:0]    held;
  logic [2:0]    pid_code;
  logic          se0_seen;

  logic       samp, line_se0, line_j, line_k, dbit, in_pkt;
  logic       bit_ev, stuff_slot, stuff_err, data_bit, byte_done, se0_ev;
  logic [7:0] byte_now;
  logic [2:0] pid_dec;
  logic       pid_ok, is_data, is_token, len_ok, overflow;
  logic       start, finish, store, push, body_inc, load_pid;

  // Line synchronizers; D+ reset to the idle J level so reset release is not a transition.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dp_s1 <= 1'b1;
      dp_s2 <= 1'b1;
      dp_d  <= 1'b1;
      dm_s1 <= 1'b0;
      dm_s2 <= 1'b0;
      cnt   <= '0;
    end else begin
      dp_s1 <= dplus_in;
      dp_s2 <= dp_s1;
      dp_d  <= dp_s2;
      dm_s1 <= dminus_in;
      dm_s2 <= dm_s1;
      if (dp_s2 != dp_d)
        cnt <= '0;
      else if (cnt == WRAP_AT)
        cnt <= '0;
      else
        cnt <= cnt + 1'b1;
    end
  end

  always_comb begin
    samp       = (cnt == SAMPLE_AT);
    line_se0   = !dp_s2 && !dm_s2;
    line_j     = dp_s2 && !dm_s2;
    line_k     = !dp_s2 && dm_s2;
    dbit       = (dp_s2 == prev_dp);
    in_pkt     = (state == SYNC) || (state == PID) || (state == BODY);
    bit_ev     = samp && !line_se0 && in_pkt;
    stuff_slot = (ones == 3'd6);
    stuff_err  = bit_ev && stuff_slot && dbit;
    data_bit   = bit_ev && !stuff_slot;
    byte_done  = data_bit && (bitcnt == 3'd7);
    byte_now   = {dbit, shift[7:1]};
    se0_ev     = samp && line_se0;
  end

  always_comb begin
    case (byte_now)
      8'hE1:   pid_dec = 3'd1;
      8'h69:   pid_dec = 3'd2;
      8'hC3:   pid_dec = 3'd3;
      8'h4B:   pid_dec = 3'd4;
      8'hD2:   pid_dec = 3'd5;
      8'h5A:   pid_dec = 3'd6;
      8'h1E:   pid_dec = 3'd7;
      default: pid_dec = 3'd0;
    endcase
    pid_ok   = (byte_now[7:4] == ~byte_now[3:0]) && (pid_dec != 3'd0);
    is_data  = (pid_code == 3'd3) || (pid_code == 3'd4);
    is_token = (pid_code == 3'd1) || (pid_code == 3'd2);
    if (is_data)
      len_ok = (body_cnt >= 8'd2) && (body_cnt <= MAX_BODY);
    else if (is_token)
      len_ok = (body_cnt == 8'd2);
    else
      len_ok = (body_cnt == 8'd0);
    overflow = (buffer_occupancy >= FIFO_FULL);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state <= IDLE;
    else
      state <= nxt;
  end

  always_comb begin
    nxt      = state;
    start    = 1'b0;
    finish   = 1'b0;
    store    = 1'b0;
    push     = 1'b0;
    body_inc = 1'b0;
    load_pid = 1'b0;
    case (state)
      IDLE: begin
        if (samp && line_k) begin
          nxt   = SYNC;
          start = 1'b1;
        end
      end
      SYNC: begin
        if (se0_ev || stuff_err)
          nxt = ERR;
        else if (byte_done)
          nxt = (byte_now == 8'h80) ? PID : ERR;
      end
      PID: begin
        if (se0_ev || stuff_err)
          nxt = ERR;
        else if (byte_done) begin
          if (pid_ok) begin
            nxt      = BODY;
            load_pid = 1'b1;
          end else
            nxt = ERR;
        end
      end
      BODY: begin
        if (stuff_err)
          nxt = ERR;
        else if (se0_ev)
          nxt = ((bitcnt == 3'd0) && len_ok) ? EOP : ERR;
        else if (byte_done) begin
          body_inc = 1'b1;
          if (is_data) begin
            // Two-deep delay line: the oldest byte leaves only once a newer pair is
            // held, so the trailing CRC16 pair never reaches the FIFO.
            if (held == 2'd2 && overflow)
              nxt = ERR;
            else begin
              push  = 1'b1;
              store = (held == 2'd2);
            end
          end
        end
      end
      EOP: begin
        if (samp && line_j) begin
          nxt    = IDLE;
          finish = 1'b1;
        end else if (samp && line_k)
          nxt = ERR;
      end
      ERR: begin
        if (samp && line_j && se0_seen) begin
          nxt    = IDLE;
          finish = 1'b1;
        end
      end
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_packet_data       <= '0;
      store_rx_packet_data <= 1'b0;
      rx_packet            <= '0;
      rx_data_ready        <= 1'b0;
      rx_transfer_active   <= 1'b0;
      rx_error             <= 1'b0;
      prev_dp              <= 1'b1;
      shift                <= '0;
      bitcnt               <= '0;
      ones                 <= '0;
      body_cnt             <= '0;
      hold0                <= '0;
      hold1                <= '0;
      held                 <= '0;
      pid_code             <= '0;
      se0_seen             <= 1'b0;
    end else begin
      store_rx_packet_data <= store;
      rx_data_ready        <= finish;
      rx_transfer_active   <= (nxt != IDLE);

      if (samp && !line_se0)
        prev_dp <= dp_s2;

      if (start) begin
        // The K that starts SYNC is already its first decoded bit (a 0).
        shift     <= '0;
        bitcnt    <= 3'd1;
        ones      <= '0;
        body_cnt  <= '0;
        held      <= '0;
        rx_error  <= 1'b0;
        rx_packet <= '0;
        se0_seen  <= 1'b0;
      end else begin
        if (bit_ev) begin
          if (stuff_slot)
            ones <= '0;
          else begin
            shift  <= byte_now;
            ones   <= dbit ? ones + 1'b1 : 3'd0;
            bitcnt <= bitcnt + 1'b1;
          end
        end
        if (body_inc && body_cnt != 8'hFF)
          body_cnt <= body_cnt + 1'b1;
        if (push) begin
          if (held == 2'd0) begin
            hold0 <= byte_now;
            held  <= 2'd1;
          end else if (held == 2'd1) begin
            hold1 <= byte_now;
            held  <= 2'd2;
          end else begin
            hold0 <= hold1;
            hold1 <= byte_now;
          end
        end
        if (nxt == ERR && state != ERR) begin
          rx_error  <= 1'b1;
          rx_packet <= '0;
          se0_seen  <= se0_ev;
        end else if (state == ERR && se0_ev)
          se0_seen <= 1'b1;
        if (finish)
          rx_packet <= (state == EOP) ? pid_code : 3'd0;
      end

      if (store)
        rx_packet_data <= hold0;
      if (load_pid)
        pid_code <= pid_dec;
    end
  end

endmodule
